instruction_fetch_queue: RTL and testbench

//  IF stage of the 5-stage MIPS core. Generates sequential fetch addresses and issues them to instruction memory

---
 rtl/instruction_fetch_queue_pkg.sv | 14 +
 rtl/instruction_fetch_queue_if.sv | 23 ++
 rtl/instruction_fetch_queue_fifo.sv | 36 +++
 rtl/instruction_fetch_queue.sv | 71 +++++++
 tb/tb_instruction_fetch_queue.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// instruction_fetch_queue_pkg: shared widths, reset PC, NOP encoding and the {pc,instr} queue entry type
package instruction_fetch_queue_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_queue_if.sv
// instruction_fetch_queue_if: imem request/response, redirect, and ID-side signals; master = fetch unit
interface instruction_fetch_queue_if;
  import instruction_fetch_queue_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic resp_valid;
  logic [INSTR_W-1:0] resp_data;
  logic redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic stall;
  logic valid;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0] pc;
  modport master (
    output req_valid, req_addr, valid, instruction, pc,
    input req_ready, resp_valid, resp_data, redirect, redirect_pc, stall
  );
  modport slave (
    input req_valid, req_addr, valid, instruction, pc,
    output req_ready, resp_valid, resp_data, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/instruction_fetch_queue_fifo.sv
// instruction_fetch_queue_fifo: DEPTH-entry {pc,instr} FIFO with push/pop/clear, occupancy count and head read
module instruction_fetch_queue_fifo
  import instruction_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= din;
  assign head = mem[rd_ptr];
endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: IF stage issuing sequential fetches with credit control, queueing words for ID, flushing on redirect
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic clk,
  input logic rst_n,
  instruction_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW:0] MAX_W = (CW+1)'(MAX_OUT);
  logic run, hs, keep, push, pop;
  logic [ADDR_W-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] count, live, drop;
  logic [CW:0] occ, infl;
  fetch_entry_t head;
  assign target = word_align(bus.redirect_pc);
  assign occ = {1'b0, count} + {1'b0, live};
  assign infl = {1'b0, live} + {1'b0, drop};
  assign bus.req_valid = run & !bus.redirect & (occ < DEPTH_W) & (infl < MAX_W);
  assign bus.req_addr = fetch_pc;
  assign hs = bus.req_valid & bus.req_ready;
  assign keep = bus.resp_valid & (drop == '0);
  assign push = keep & !bus.redirect;
  assign bus.valid = (count != '0) & !bus.redirect;
  assign pop = bus.valid & !bus.stall;
  assign bus.instruction = bus.valid ? head.instr : NOP_INSTR;
  assign bus.pc = bus.valid ? head.pc : '0;
  instruction_fetch_queue_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .clear(bus.redirect),
    .din({resp_pc, bus.resp_data}),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      live <= '0;
      drop <= '0;
    end else begin
      run <= 1'b1;
      if (bus.redirect) begin
        fetch_pc <= target;
        resp_pc <= target;
        live <= '0;
        drop <= drop + live - CW'(bus.resp_valid);
      end else begin
        fetch_pc <= hs ? fetch_pc + ADDR_W'(4) : fetch_pc;
        resp_pc <= push ? resp_pc + ADDR_W'(4) : resp_pc;
        live <= live + CW'(hs) - CW'(keep);
        drop <= drop - CW'(bus.resp_valid & !keep);
      end
    end
  always @(posedge clk)
    if (rst_n) begin
      assert ({1'b0, count} <= DEPTH_W);
      assert (infl <= MAX_W);
      assert (occ <= DEPTH_W);
      assert (!(bus.resp_valid && infl == '0));
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: randomized imem/ID environment checked against a per-request reference model
module tb_instruction_fetch_queue;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  typedef struct {logic [31:0] addr; bit kept; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  logic clk = 0;
  logic rst_n = 0;
  instruction_fetch_queue_if b();
  instruction_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b)
  );
  always #5 clk = ~clk;
  req_t pend[$];
  ent_t q[$];
  logic [31:0] hs_log[$];
  logic [31:0] exp_fetch, rd_target, fv_pc, hp, hi;
  int n_cmp = 0, n_err = 0, cyc = 0, first_valid = 0, idx;
  int ready_p, stall_p, redir_pm, lat_lo, lat_hi;
  bit rd_on_resp = 0, force_rd = 0, watch = 0;
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic do_reset();
    b.req_ready = 0;
    b.resp_valid = 0;
    b.resp_data = 0;
    b.redirect = 0;
    b.redirect_pc = 0;
    b.stall = 0;
    #1 rst_n = 0;
    pend.delete();
    q.delete();
    exp_fetch = RST_PC;
    cyc = 0;
    first_valid = 0;
    #3;
    chk("rst_req_valid", b.req_valid, 0);
    chk("rst_valid", b.valid, 0);
    chk("rst_instr", b.instruction, 0);
    chk("rst_pc", b.pc, 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("rst_release_req", b.req_valid, 0);
  endtask
  task automatic step();
    int live, drop;
    bit ev, er, rsp;
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    b.req_ready = $urandom_range(99) < ready_p;
    b.stall = $urandom_range(99) < stall_p;
    rsp = pend.size() > 0 && pend[0].due <= cyc;
    b.resp_valid = rsp;
    b.resp_data = rsp ? imem(pend[0].addr) : $urandom;
    b.redirect = force_rd || (rd_on_resp && rsp && q.size() > 0) || ($urandom_range(999) < redir_pm);
    b.redirect_pc = force_rd ? rd_target : $urandom;
    force_rd = 0;
    #4;
    live = 0;
    drop = 0;
    foreach (pend[i]) if (pend[i].kept) live++; else drop++;
    ev = q.size() > 0 && !b.redirect;
    er = !b.redirect && (q.size() + live < DEPTH) && (live + drop < MAX_OUT);
    chk("valid", b.valid, ev);
    if (ev) begin
      chk("instr", b.instruction, q[0].ins);
      chk("pc", b.pc, q[0].pc);
    end else begin
      chk("instr_nop", b.instruction, 0);
      chk("pc_zero", b.pc, 0);
    end
    chk("req_valid", b.req_valid, er);
    if (er) chk("req_addr", b.req_addr, exp_fetch);
    if (b.valid && first_valid == 0) first_valid = cyc;
    if (watch && b.valid) begin
      fv_pc = b.pc;
      watch = 0;
    end
    if (b.req_valid && b.req_ready) hs_log.push_back(b.req_addr);
    if (ev && !b.stall) void'(q.pop_front());
    if (rsp) begin
      r = pend.pop_front();
      if (r.kept && !b.redirect) q.push_back('{r.addr, imem(r.addr)});
    end
    if (b.redirect) begin
      q.delete();
      foreach (pend[i]) pend[i].kept = 0;
      exp_fetch = {b.redirect_pc[31:2], 2'b00};
    end
    if (er && b.req_ready) begin
      pend.push_back('{exp_fetch, 1'b1, cyc + $urandom_range(lat_hi, lat_lo)});
      exp_fetch += 4;
    end
  endtask
  initial begin
    ready_p = 100; stall_p = 0; redir_pm = 0; lat_lo = 1; lat_hi = 1;
    do_reset();
    repeat (20) step();
    chk("t1_addr0", hs_log[0], 32'hBFC0_0000);
    chk("t1_addr1", hs_log[1], 32'hBFC0_0004);
    chk("t1_first_valid_cycle", first_valid, 3);
    stall_p = 100;
    step();
    hp = b.pc;
    hi = b.instruction;
    repeat (9) step();
    chk("t2_stall_req", b.req_valid, 0);
    chk("t2_stall_valid", b.valid, 1);
    chk("t2_stall_pc", b.pc, hp);
    chk("t2_stall_instr", b.instruction, hi);
    stall_p = 0;
    repeat (20) step();
    lat_lo = 3; lat_hi = 3;
    repeat (10) step();
    idx = hs_log.size();
    rd_target = 32'h0040_0103;
    force_rd = 1;
    watch = 1;
    repeat (15) step();
    chk("t3_redir_addr", hs_log.size() > idx ? hs_log[idx] : 32'hDEAD_DEAD, 32'h0040_0100);
    chk("t3_first_pc", fv_pc, 32'h0040_0100);
    lat_lo = 1; lat_hi = 1; rd_on_resp = 1;
    repeat (30) step();
    rd_on_resp = 0;
    repeat (5) step();
    idx = hs_log.size();
    rd_target = 32'hFFFF_FFF8;
    force_rd = 1;
    repeat (8) step();
    chk("t5_wrap0", hs_log.size() > idx ? hs_log[idx] : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
    chk("t5_wrap1", hs_log.size() > idx + 1 ? hs_log[idx+1] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
    chk("t5_wrap2", hs_log.size() > idx + 2 ? hs_log[idx+2] : 32'hDEAD_DEAD, 32'h0000_0000);
    ready_p = 70; stall_p = 30; redir_pm = 20; lat_lo = 1; lat_hi = 3;
    repeat (5000) step();
    do_reset();
    repeat (5000) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
